// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS pipeline.
// Fetch-stage state encoding and address helpers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  function automatic word_t align_pc(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, npc} holding register.
// Captures a fetched word while IF/ID is stalled.
module fetch_skid_buffer
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t npc_o
);

  logic  valid_q;
  word_t instr_q;
  word_t npc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      npc_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      npc_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      npc_q   <= npc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, feeds IF/ID,
// and parks a word in the skid buffer on a stall.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        ifid_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        cnt_q;
  word_t        pc_plus4;
  logic         buf_load, buf_clear;
  logic         buf_valid;
  word_t        buf_instr, buf_npc;

  assign pc_plus4 = pc_q + PC_STEP;

  fetch_skid_buffer u_skid (
    .clk     (CLK),
    .rst     (RST),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (imemload),
    .npc_i   (pc_plus4),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .npc_o   (buf_npc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // redirect outranks halt: a halt alongside it is from a squashed path
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = align_pc(redirect_pc);
        end else if (halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          pc_d = pc_plus4;
          if (!ifid_ready) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d      = align_pc(redirect_pc);
          buf_clear = 1'b1;
          state_d   = FETCH;
        end else if (halt) begin
          buf_clear = 1'b1;
          state_d   = HALTED;
        end else if (ifid_ready) begin
          buf_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    imemREN         = 1'b0;
    if_valid        = 1'b0;
    instruction_out = '0;
    npc_out         = '0;
    unique case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit && !redirect && !halt) begin
          if_valid        = 1'b1;
          instruction_out = imemload;
          npc_out         = pc_plus4;
        end
      end
      HOLD: begin
        if (buf_valid && !redirect && !halt) begin
          if_valid        = 1'b1;
          instruction_out = buf_instr;
          npc_out         = buf_npc;
        end
      end
      default: begin
        imemREN = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (if_valid && ifid_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign imemaddr    = pc_q;
  assign fetch_count = cnt_q;

endmodule
